univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register with a counted-burst sequencer. Supports hold, logical/arithmetic shift, rotate, parallel load and clear under direct per-cycle mode control, plus an autonomous burst that applies N shifts and reports completion. It is the general-purpose storage/serialiser element for the datapath, used for serial links and bit-serial arithmetic.

## Interface
Parameters:
- WIDTH, 8: register width in bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH)+2: burst count width; allows bursts longer than WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge only.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable; 0 freezes q and the burst counter.
- mode  in  3  direct operation, used only while idle.
- d  in  WIDTH  parallel load data.
- sin_lsb  in  1  serial input entering at bit 0 on left shift.
- sin_msb  in  1  serial input entering at bit WIDTH-1 on right shift.
- start  in  1  burst request, sampled while idle.
- burst_dir  in  2  burst operation: 00 shl, 01 shr, 10 rol, 11 ror.
- burst_n  in  CNT_W  number of burst shifts.
- q  out  WIDTH  register contents.
- sout_msb  out  1  equals q[WIDTH-1].
- sout_lsb  out  1  equals q[0].
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- Mode encodings:
  - 000 hold.
  - 001 shl: q <= {q[W-2:0], sin_lsb}.
  - 010 shr: q <= {sin_msb, q[W-1:1]}.
  - 011 rol.
  - 100 ror.
  - 101 load d.
  - 110 asr: MSB replicated.
  - 111 clear to 0.
- FSM states:
  - IDLE: direct mode applies on each edge with en=1 and start=0.
  - BUSY: burst in progress.
- Start handling in IDLE, when start=1:
  - Latch burst_dir and load cnt <= burst_n.
  - No mode operation is applied on that edge; start has priority over mode.
  - If burst_n=0: stay in IDLE, q unchanged, done pulses next cycle.
  - Otherwise go to BUSY.
- start is accepted regardless of en.
- BUSY, on each edge with en=1:
  - Apply the latched burst_dir shift.
  - cnt <= cnt-1.
  - On the edge where cnt==1, return to IDLE and set done.
- BUSY, on edges with en=0: q, cnt and state are held; the burst pauses.
- BUSY ignores mode, start and d; a start received while busy is dropped, not queued.
- Serial inputs are sampled on every shift edge, including burst edges.
- burst_n > WIDTH is legal: all shifts are performed. For example, rol by WIDTH returns q to its original value.
- Reset:
  - q=0, busy=0, done=0, cnt=0, state IDLE.
  - A reset mid-burst aborts the burst with no done pulse.
  - rst has priority over every other input.

## Timing
- Direct op: result visible on q in the cycle after the sampling edge (latency 1).
- Burst with start at edge t and n ≥ 1 (en held high):
  - busy is high from cycle t+1 through the cycle ending at edge t+n.
  - The k-th shift occurs at edge t+k.
  - Final q and done=1 both appear after edge t+n; busy=0 at that time.
- Burst with n=0: done=1 in the cycle after edge t; busy never asserts.
- done is registered and high for exactly one cycle.
- A new start may be presented in the same cycle done is high; it is accepted.
- Each cycle with en low during a burst extends busy by one cycle.
- sout_msb and sout_lsb are combinational from q, so there are no extra cycles.

## Structure
- Package shift_pkg holds:
  - mode_t: 3-bit enum of the eight modes.
  - dir_t: 2-bit burst direction enum.
  - state_t: IDLE, BUSY.
- Sub-module shift_unit: combinational next-value function (q, op, sin_lsb, sin_msb, d → q_next), shared by the direct and burst paths.
- Burst directions are mapped onto the corresponding mode_t ops before entering shift_unit.
- The top level holds the q register, cnt, FSM and done flag.

## Test plan
- Reset with WIDTH=8 → q=0x00, busy=0, done=0. Then rst while busy mid-burst → q=0x00, IDLE, no done pulse.
- load d=0xA5, then shl with sin_lsb=1 → 0x4B; then asr → 0x25; then ror → 0x92; then clear → 0x00.
- q=0x81, start, burst_dir=rol, burst_n=3 → q=0x0C three edges after start; busy high for 3 cycles; done pulses once alongside the final value.
- Burst shr, n=4, with en low for 2 cycles mid-burst → busy lasts 6 cycles; q=0x0F from 0xF0 with sin_msb=0; a start asserted mid-burst is ignored.
- burst_n=0 → done next cycle, busy stays 0, q unchanged. burst_n=8 rol on 0x3C → q=0x3C after 8 shifts.
- start and mode=load asserted on the same edge → burst taken, d not loaded. New start in the done cycle → second burst runs back-to-back.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: direct modes, burst directions,
// sequencer states, and the mapping from burst direction onto a direct mode.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_t;

  typedef enum logic [1:0] {
    DIR_SHL = 2'b00,
    DIR_SHR = 2'b01,
    DIR_ROL = 2'b10,
    DIR_ROR = 2'b11
  } dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Bursts reuse the direct-mode datapath, so each direction maps to its mode op
  function automatic mode_t dir_to_mode(input dir_t dir);
    mode_t m;
    case (dir)
      DIR_SHL: m = MODE_SHL;
      DIR_SHR: m = MODE_SHR;
      DIR_ROL: m = MODE_ROL;
      DIR_ROR: m = MODE_ROR;
      default: m = MODE_HOLD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/shift_unit.sv
// Combinational next-value function of the shift register, shared by the
// direct-mode path and the burst sequencer.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            op,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      MODE_HOLD:  q_next = q;
      MODE_SHL:   q_next = {q[WIDTH-2:0], sin_lsb};
      MODE_SHR:   q_next = {sin_msb, q[WIDTH-1:1]};
      MODE_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:   q_next = {q[0], q[WIDTH-1:1]};
      MODE_LOAD:  q_next = d;
      MODE_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_CLEAR: q_next = '0;
      default:    q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with a counted-burst sequencer: direct per-cycle
// mode control while idle, or an autonomous burst of N shifts ending in a done pulse.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic             start,
  input  logic [1:0]       burst_dir,
  input  logic [CNT_W-1:0] burst_n,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  state_t           state;
  dir_t             dir;
  logic [CNT_W-1:0] cnt;
  mode_t            op;
  logic [WIDTH-1:0] q_next;

  // While a burst runs the latched direction drives the datapath; otherwise mode does
  always_comb begin
    op = mode_t'(mode);
    if (state == BUSY) op = dir_to_mode(dir);
  end

  shift_unit #(
    .WIDTH(WIDTH)
  ) u_shift_unit (
    .q       (q),
    .op      (op),
    .sin_lsb (sin_lsb),
    .sin_msb (sin_msb),
    .d       (d),
    .q_next  (q_next)
  );

  // start wins over mode and ignores en; a zero-length burst only produces done
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      cnt   <= '0;
      dir   <= DIR_SHL;
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dir <= dir_t'(burst_dir);
            cnt <= burst_n;
            if (burst_n == '0) done  <= 1'b1;
            else               state <= BUSY;
          end else if (en) begin
            q <= q_next;
          end
        end
        BUSY: begin
          if (en) begin
            q   <= q_next;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == BUSY);
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: a table of direct-mode vectors plus
// hand-written burst sequences, all compared through an expected-value queue.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH) + 2;

  logic             clk;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_lsb;
  logic             sin_msb;
  logic             start;
  logic [1:0]       burst_dir;
  logic [CNT_W-1:0] burst_n;
  logic [WIDTH-1:0] q;
  logic             sout_msb;
  logic             sout_lsb;
  logic             busy;
  logic             done;

  typedef struct {
    string            name;
    logic             rst;
    logic             en;
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sl;
    logic             sm;
    logic [1:0]       dir;
    logic [CNT_W-1:0] n;
    logic [WIDTH-1:0] eq;
    logic             ebusy;
    logic             edone;
  } vec_t;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  univ_shift_reg #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .d         (d),
    .sin_lsb   (sin_lsb),
    .sin_msb   (sin_msb),
    .start     (start),
    .burst_dir (burst_dir),
    .burst_n   (burst_n),
    .q         (q),
    .sout_msb  (sout_msb),
    .sout_lsb  (sout_lsb),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input string name, input logic r, input logic e, input logic s,
                              input logic [2:0] m, input logic [WIDTH-1:0] dd,
                              input logic sl, input logic sm, input logic [1:0] dr,
                              input logic [CNT_W-1:0] n, input logic [WIDTH-1:0] eq,
                              input logic eb, input logic ed);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.start = s; v.mode = m; v.d = dd;
    v.sl = sl; v.sm = sm; v.dir = dr; v.n = n; v.eq = eq; v.ebusy = eb; v.edone = ed;
    return v;
  endfunction

  // Plain cycle with mode=hold, no start, serial inputs low
  function automatic vec_t idle(input string name, input logic e, input logic [WIDTH-1:0] eq,
                                input logic eb, input logic ed);
    return mk(name, 1'b0, e, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 2'b00, '0, eq, eb, ed);
  endfunction

  task automatic check1(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: actual=0 entries required=1");
      return;
    end
    e = sb.pop_front();
    check1({e.name, ".q"},        q,                 e.q);
    check1({e.name, ".busy"},     {7'b0, busy},      {7'b0, e.busy});
    check1({e.name, ".done"},     {7'b0, done},      {7'b0, e.done});
    check1({e.name, ".sout_msb"}, {7'b0, sout_msb},  {7'b0, e.q[WIDTH-1]});
    check1({e.name, ".sout_lsb"}, {7'b0, sout_lsb},  {7'b0, e.q[0]});
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst; en = v.en; start = v.start; mode = v.mode; d = v.d;
    sin_lsb = v.sl; sin_msb = v.sm; burst_dir = v.dir; burst_n = v.n;
    e.name = v.name; e.q = v.eq; e.busy = v.ebusy; e.done = v.edone;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; mode = 3'b000; d = '0;
    sin_lsb = 1'b0; sin_msb = 1'b0; burst_dir = 2'b00; burst_n = '0;

    // Direct-mode table: {inputs, expected q/busy/done after the edge}
    vecs.push_back(mk("reset",       1, 0, 0, 3'b000, 8'h00, 0, 0, 2'b00, 0, 8'h00, 0, 0));
    vecs.push_back(mk("load_a5",     0, 1, 0, 3'b101, 8'hA5, 0, 0, 2'b00, 0, 8'hA5, 0, 0));
    vecs.push_back(mk("shl_sl1",     0, 1, 0, 3'b001, 8'h00, 1, 0, 2'b00, 0, 8'h4B, 0, 0));
    vecs.push_back(mk("asr_pos",     0, 1, 0, 3'b110, 8'h00, 0, 0, 2'b00, 0, 8'h25, 0, 0));
    vecs.push_back(mk("ror",         0, 1, 0, 3'b100, 8'h00, 0, 0, 2'b00, 0, 8'h92, 0, 0));
    vecs.push_back(mk("clear",       0, 1, 0, 3'b111, 8'h00, 0, 0, 2'b00, 0, 8'h00, 0, 0));
    vecs.push_back(mk("load_96",     0, 1, 0, 3'b101, 8'h96, 0, 0, 2'b00, 0, 8'h96, 0, 0));
    vecs.push_back(mk("shr_sm1",     0, 1, 0, 3'b010, 8'h00, 0, 1, 2'b00, 0, 8'hCB, 0, 0));
    vecs.push_back(mk("rol",         0, 1, 0, 3'b011, 8'h00, 0, 0, 2'b00, 0, 8'h97, 0, 0));
    vecs.push_back(mk("shl_sl0",     0, 1, 0, 3'b001, 8'h00, 0, 1, 2'b00, 0, 8'h2E, 0, 0));
    vecs.push_back(mk("load_80",     0, 1, 0, 3'b101, 8'h80, 0, 0, 2'b00, 0, 8'h80, 0, 0));
    vecs.push_back(mk("asr_neg",     0, 1, 0, 3'b110, 8'h00, 0, 0, 2'b00, 0, 8'hC0, 0, 0));
    vecs.push_back(mk("en0_frozen",  0, 0, 0, 3'b111, 8'h00, 0, 0, 2'b00, 0, 8'hC0, 0, 0));
    vecs.push_back(mk("hold",        0, 1, 0, 3'b000, 8'hFF, 1, 1, 2'b00, 0, 8'hC0, 0, 0));
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Burst rol n=3 from 0x81; start coincides with mode=load, which must be ignored
    applyStimulus(mk("pre81",      0, 1, 0, 3'b101, 8'h81, 0, 0, 2'b00, 0, 8'h81, 0, 0));
    applyStimulus(mk("rol3_start", 0, 1, 1, 3'b101, 8'hFF, 0, 0, 2'b10, 3, 8'h81, 1, 0));
    applyStimulus(idle("rol3_k1", 1, 8'h03, 1, 0));
    applyStimulus(idle("rol3_k2", 1, 8'h06, 1, 0));
    applyStimulus(idle("rol3_k3", 1, 8'h0C, 0, 1));
    applyStimulus(idle("rol3_after", 1, 8'h0C, 0, 0));

    // Burst shr n=4 from 0xF0, two en-low cycles and a dropped start mid-burst
    applyStimulus(mk("preF0",      0, 1, 0, 3'b101, 8'hF0, 0, 0, 2'b00, 0, 8'hF0, 0, 0));
    applyStimulus(mk("shr4_start", 0, 1, 1, 3'b000, 8'h00, 0, 0, 2'b01, 4, 8'hF0, 1, 0));
    applyStimulus(idle("shr4_k1", 1, 8'h78, 1, 0));
    applyStimulus(mk("shr4_pause1", 0, 0, 1, 3'b111, 8'h00, 1, 1, 2'b10, 2, 8'h78, 1, 0));
    applyStimulus(mk("shr4_pause2", 0, 0, 0, 3'b101, 8'hFF, 0, 1, 2'b00, 0, 8'h78, 1, 0));
    applyStimulus(mk("shr4_k2",    0, 1, 1, 3'b101, 8'hFF, 0, 0, 2'b11, 5, 8'h3C, 1, 0));
    applyStimulus(idle("shr4_k3", 1, 8'h1E, 1, 0));
    applyStimulus(idle("shr4_k4", 1, 8'h0F, 0, 1));
    applyStimulus(idle("shr4_no_requeue", 1, 8'h0F, 0, 0));

    // Zero-length burst: done next cycle, no busy, q unchanged, even with en low
    applyStimulus(mk("n0_start", 0, 0, 1, 3'b111, 8'h00, 0, 0, 2'b00, 0, 8'h0F, 0, 1));
    applyStimulus(idle("n0_after", 1, 8'h0F, 0, 0));

    // rol by WIDTH returns the original value, then a back-to-back ror started in the done cycle
    applyStimulus(mk("pre3C",      0, 1, 0, 3'b101, 8'h3C, 0, 0, 2'b00, 0, 8'h3C, 0, 0));
    applyStimulus(mk("rol8_start", 0, 1, 1, 3'b000, 8'h00, 0, 0, 2'b10, 8, 8'h3C, 1, 0));
    applyStimulus(idle("rol8_k1", 1, 8'h78, 1, 0));
    applyStimulus(idle("rol8_k2", 1, 8'hF0, 1, 0));
    applyStimulus(idle("rol8_k3", 1, 8'hE1, 1, 0));
    applyStimulus(idle("rol8_k4", 1, 8'hC3, 1, 0));
    applyStimulus(idle("rol8_k5", 1, 8'h87, 1, 0));
    applyStimulus(idle("rol8_k6", 1, 8'h0F, 1, 0));
    applyStimulus(idle("rol8_k7", 1, 8'h1E, 1, 0));
    applyStimulus(idle("rol8_k8", 1, 8'h3C, 0, 1));
    applyStimulus(mk("b2b_start",  0, 1, 1, 3'b101, 8'hFF, 0, 0, 2'b11, 2, 8'h3C, 1, 0));
    applyStimulus(idle("b2b_k1", 1, 8'h1E, 1, 0));
    applyStimulus(idle("b2b_k2", 1, 8'h0F, 0, 1));

    // Burst shl samples sin_lsb on each burst edge
    applyStimulus(mk("shl2_start", 0, 1, 1, 3'b000, 8'h00, 0, 0, 2'b00, 2, 8'h0F, 1, 0));
    applyStimulus(mk("shl2_k1",    0, 1, 0, 3'b000, 8'h00, 1, 0, 2'b00, 0, 8'h1F, 1, 0));
    applyStimulus(mk("shl2_k2",    0, 1, 0, 3'b000, 8'h00, 0, 0, 2'b00, 0, 8'h3E, 0, 1));

    // Reset mid-burst aborts with no done pulse
    applyStimulus(mk("ror5_start", 0, 1, 1, 3'b000, 8'h00, 0, 0, 2'b11, 5, 8'h3E, 1, 0));
    applyStimulus(idle("ror5_k1", 1, 8'h1F, 1, 0));
    applyStimulus(mk("abort_rst",  1, 1, 1, 3'b101, 8'hFF, 1, 1, 2'b00, 3, 8'h00, 0, 0));
    applyStimulus(idle("abort_after1", 1, 8'h00, 0, 0));
    applyStimulus(idle("abort_after2", 1, 8'h00, 0, 0));

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: actual=%0d entries required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
